// File: rtl/keyboard_pkg.sv
// Shared definitions for the keyboard voice tracker: PS/2 scan codes,
// note encoding, parser state type and key-decode helpers.
package keyboard_pkg;

    // Prefix and control scan codes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // Note key scan codes
    localparam logic [7:0] SC_NOTE_A  = 8'h1C;
    localparam logic [7:0] SC_NOTE_AS = 8'h15;
    localparam logic [7:0] SC_NOTE_B  = 8'h1B;
    localparam logic [7:0] SC_NOTE_C  = 8'h23;
    localparam logic [7:0] SC_NOTE_CS = 8'h24;
    localparam logic [7:0] SC_NOTE_D  = 8'h2B;
    localparam logic [7:0] SC_NOTE_DS = 8'h2D;
    localparam logic [7:0] SC_NOTE_E  = 8'h34;
    localparam logic [7:0] SC_NOTE_F  = 8'h33;
    localparam logic [7:0] SC_NOTE_FS = 8'h35;
    localparam logic [7:0] SC_NOTE_G  = 8'h3B;
    localparam logic [7:0] SC_NOTE_GS = 8'h3C;

    // Octave key scan codes (number row 1..8 -> octave 0..7)
    localparam logic [7:0] SC_OCT_0 = 8'h16;
    localparam logic [7:0] SC_OCT_1 = 8'h1E;
    localparam logic [7:0] SC_OCT_2 = 8'h26;
    localparam logic [7:0] SC_OCT_3 = 8'h25;
    localparam logic [7:0] SC_OCT_4 = 8'h2E;
    localparam logic [7:0] SC_OCT_5 = 8'h36;
    localparam logic [7:0] SC_OCT_6 = 8'h3D;
    localparam logic [7:0] SC_OCT_7 = 8'h3E;

    // 4-bit note encoding; zero marks an empty slot
    typedef enum logic [3:0] {
        NOTE_NONE = 4'd0,  NOTE_A  = 4'd1,  NOTE_AS = 4'd2,  NOTE_B  = 4'd3,
        NOTE_C    = 4'd4,  NOTE_CS = 4'd5,  NOTE_D  = 4'd6,  NOTE_DS = 4'd7,
        NOTE_E    = 4'd8,  NOTE_F  = 4'd9,  NOTE_FS = 4'd10, NOTE_G  = 4'd11,
        NOTE_GS   = 4'd12
    } note_e;

    typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK} parser_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] index;
    } octave_key_t;

    function automatic note_e decode_note(input logic [7:0] code);
        case (code)
            SC_NOTE_A:  return NOTE_A;
            SC_NOTE_AS: return NOTE_AS;
            SC_NOTE_B:  return NOTE_B;
            SC_NOTE_C:  return NOTE_C;
            SC_NOTE_CS: return NOTE_CS;
            SC_NOTE_D:  return NOTE_D;
            SC_NOTE_DS: return NOTE_DS;
            SC_NOTE_E:  return NOTE_E;
            SC_NOTE_F:  return NOTE_F;
            SC_NOTE_FS: return NOTE_FS;
            SC_NOTE_G:  return NOTE_G;
            SC_NOTE_GS: return NOTE_GS;
            default:    return NOTE_NONE;
        endcase
    endfunction

    function automatic octave_key_t decode_octave(input logic [7:0] code);
        octave_key_t k;
        k.valid = 1'b1;
        case (code)
            SC_OCT_0: k.index = 3'd0;
            SC_OCT_1: k.index = 3'd1;
            SC_OCT_2: k.index = 3'd2;
            SC_OCT_3: k.index = 3'd3;
            SC_OCT_4: k.index = 3'd4;
            SC_OCT_5: k.index = 3'd5;
            SC_OCT_6: k.index = 3'd6;
            SC_OCT_7: k.index = 3'd7;
            default: begin
                k.valid = 1'b0;
                k.index = 3'd0;
            end
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// PS/2 make/break/extended prefix parser. Emits a combinational one-cycle
// key event in the same cycle as the final byte of a sequence.
module ps2_scan_parser
    import keyboard_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic       event_valid,
    output logic       event_is_break,
    output logic [7:0] event_code
);

    parser_state_e r_state;
    parser_state_e w_state_nx;

    // State register; reset drops any half-received prefix
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // Next state and event decode; extended sequences are swallowed
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_state_nx     = r_state;
        event_valid    = 1'b0;
        event_is_break = 1'b0;
        event_code     = scan_code;
        if (scan_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)        w_state_nx = ST_EXT;
                    else if (scan_code == SC_BREAK) w_state_nx = ST_BREAK;
                    else                            event_valid = 1'b1;
                end
                ST_BREAK: begin
                    event_valid    = 1'b1;
                    event_is_break = 1'b1;
                    w_state_nx     = ST_IDLE;
                end
                ST_EXT: begin
                    if (scan_code == SC_BREAK) w_state_nx = ST_EXT_BREAK;
                    else                       w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keyboard_voice_tracker.sv
// Polyphonic key tracker: voice slot table with dedupe, lowest-free
// allocation and optional round-robin stealing, plus octave register
// and active-low load/playback strobes.
module keyboard_voice_tracker
    import keyboard_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int OCTAVE_W   = 2,
    parameter bit STEAL      = 1'b0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [7:0]                     scan_code,
    input  logic                           scan_valid,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [4*NUM_VOICES-1:0]        voice_note,
    output logic [OCTAVE_W*NUM_VOICES-1:0] voice_octave,
    output logic [OCTAVE_W-1:0]            octave,
    output logic [$clog2(NUM_VOICES+1)-1:0] held_count,
    output logic                           load_n,
    output logic                           playback_n,
    output logic                           overflow
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int HC_W  = $clog2(NUM_VOICES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    logic                  w_ev_valid, w_ev_break;
    logic [7:0]            w_ev_code;

    logic [NUM_VOICES-1:0] r_active, w_active_nx;
    note_e                 r_note [NUM_VOICES];
    note_e                 w_note_nx [NUM_VOICES];
    logic [OCTAVE_W-1:0]   r_oct [NUM_VOICES];
    logic [OCTAVE_W-1:0]   w_oct_nx [NUM_VOICES];
    logic [OCTAVE_W-1:0]   r_octave, w_octave_nx;
    logic [IDX_W-1:0]      r_steal_ptr, w_steal_ptr_nx;
    logic [HC_W-1:0]       r_held, w_held_nx;
    logic                  r_load_n, r_playback_n, r_overflow;
    logic                  w_load_n_nx, w_playback_n_nx, w_overflow_nx;

    note_e                 w_key_note;
    octave_key_t           w_oct_key;
    logic                  w_oct_ok;
    logic                  w_hit, w_free;
    logic [IDX_W-1:0]      w_hit_idx, w_free_idx;

    ps2_scan_parser u_parser (
        .clock          (clock),
        .reset          (reset),
        .scan_code      (scan_code),
        .scan_valid     (scan_valid),
        .event_valid    (w_ev_valid),
        .event_is_break (w_ev_break),
        .event_code     (w_ev_code)
    );

    assign w_key_note = decode_note(w_ev_code);
    assign w_oct_key  = decode_octave(w_ev_code);
    assign w_oct_ok   = w_oct_key.valid && (int'(w_oct_key.index) < (1 << OCTAVE_W));

    // Locate the slot already holding this note and the lowest free slot
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_active[i] && (r_note[i] == w_key_note)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_active[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Apply the current key event to the voice table, octave and strobes
    always_comb begin
        w_active_nx     = r_active;
        w_note_nx       = r_note;
        w_oct_nx        = r_oct;
        w_octave_nx     = r_octave;
        w_steal_ptr_nx  = r_steal_ptr;
        w_load_n_nx     = 1'b1;
        w_playback_n_nx = 1'b1;
        w_overflow_nx   = 1'b0;
        if (w_ev_valid) begin
            if (w_key_note != NOTE_NONE) begin
                if (w_ev_break) begin
                    if (w_hit) begin
                        w_active_nx[w_hit_idx] = 1'b0;
                        w_note_nx[w_hit_idx]   = NOTE_NONE;
                        w_oct_nx[w_hit_idx]    = '0;
                    end
                end else if (!w_hit) begin
                    if (w_free) begin
                        w_active_nx[w_free_idx] = 1'b1;
                        w_note_nx[w_free_idx]   = w_key_note;
                        w_oct_nx[w_free_idx]    = r_octave;
                    end else begin
                        w_overflow_nx = 1'b1;
                        if (STEAL) begin
                            w_note_nx[r_steal_ptr] = w_key_note;
                            w_oct_nx[r_steal_ptr]  = r_octave;
                            w_steal_ptr_nx = (r_steal_ptr == LAST_IDX) ? '0 : r_steal_ptr + 1'b1;
                        end
                    end
                end
            end else if (!w_ev_break) begin
                if (w_oct_ok)                    w_octave_nx     = w_oct_key.index[OCTAVE_W-1:0];
                else if (w_ev_code == SC_SPACE)  w_load_n_nx     = 1'b0;
                else if (w_ev_code == SC_ENTER)  w_playback_n_nx = 1'b0;
            end
        end
    end

    // Popcount of the next active vector, registered alongside it
    always_comb begin
        w_held_nx = '0;
        for (int i = 0; i < NUM_VOICES; i++) w_held_nx = w_held_nx + HC_W'(w_active_nx[i]);
    end

    // Table, octave, pointer and strobe registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active <= '0;
            // NOTE: the slot array is a handful of flops that must read empty after reset, so it is reset explicitly.
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= NOTE_NONE;
                r_oct[i]  <= '0;
            end
            r_octave     <= '0;
            r_steal_ptr  <= '0;
            r_held       <= '0;
            r_load_n     <= 1'b1;
            r_playback_n <= 1'b1;
            r_overflow   <= 1'b0;
        end else begin
            r_active     <= w_active_nx;
            r_note       <= w_note_nx;
            r_oct        <= w_oct_nx;
            r_octave     <= w_octave_nx;
            r_steal_ptr  <= w_steal_ptr_nx;
            r_held       <= w_held_nx;
            r_load_n     <= w_load_n_nx;
            r_playback_n <= w_playback_n_nx;
            r_overflow   <= w_overflow_nx;
        end
    end

    // Flatten slot arrays onto the output buses
    always_comb begin
        voice_note   = '0;
        voice_octave = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[4*i +: 4]                = r_note[i];
            voice_octave[OCTAVE_W*i +: OCTAVE_W] = r_oct[i];
        end
    end

    assign voice_active = r_active;
    assign octave       = r_octave;
    assign held_count   = r_held;
    assign load_n       = r_load_n;
    assign playback_n   = r_playback_n;
    assign overflow     = r_overflow;

endmodule
